key_cmd_scheduler: RTL and testbench

//  Sits between Keyboard (key_num/key) and game FSM. Turns held-key levels into

---
 rtl/key_cmd_scheduler.sv | 138 +++++++++++++
 tb/tb_key_cmd_scheduler.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/key_cmd_scheduler.sv
// Converts held-key levels from the keyboard into discrete move/confirm commands
// with auto-repeat for directions, buffered in a small FIFO for the game FSM.
module key_cmd_scheduler #(
   parameter int REPEAT_DELAY  = 50_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [2:0]                    key_num,
   input  logic                          key,
   input  logic                          cmd_ready,
   output logic                          cmd_valid,
   output logic [2:0]                    cmd_dir,
   output logic                          cmd_repeat,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          overflow
);

   localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int FCNT_W  = PTR_W + 1;

   localparam logic [CNT_W-1:0]  DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
   localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);
   localparam logic [FCNT_W-1:0] FIFO_FULL   = FCNT_W'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HOLD} state_t;

   state_t            state;
   logic [CNT_W-1:0]  cnt;
   logic              key_q;
   logic [2:0]        num_q;
   logic [2:0]        dir_q;

   logic              press;
   logic              rel;
   logic              expire;
   logic              push;
   logic [2:0]        push_dir;
   logic              push_rep;

   // A change of key_num while held counts as a fresh press of the new key.
   assign press = key & (~key_q | (key_num != num_q)) & (key_num <= 3'd4);
   assign rel   = ~key | (key_num > 3'd4);

   assign expire = ((state == DELAY)  && (cnt == DELAY_LAST)) ||
                   ((state == REPEAT) && (cnt == PERIOD_LAST));

   // press and rel are mutually exclusive; rel only blocks a repeat push.
   assign push     = press | (expire & ~rel);
   assign push_dir = press ? key_num : dir_q;
   assign push_rep = ~press;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
         key_q <= 1'b0;
         num_q <= 3'd5;
         dir_q <= 3'd0;
      end else begin
         key_q <= key;
         num_q <= key_num;
         if ((state != IDLE) && rel) begin
            state <= IDLE;
            cnt   <= '0;
         end else if (press) begin
            dir_q <= key_num;
            cnt   <= '0;
            state <= (key_num == 3'd4) ? HOLD : DELAY;
         end else begin
            case (state)
               DELAY: begin
                  if (cnt == DELAY_LAST) begin
                     state <= REPEAT;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               REPEAT: begin
                  if (cnt == PERIOD_LAST) cnt <= '0;
                  else                    cnt <= cnt + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   // Handshake: an entry transfers on any cycle with cmd_valid & cmd_ready;
   // cmd_valid stays high with stable head data until that transfer happens.
   logic [2:0]        dir_mem [FIFO_DEPTH];
   logic              rep_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [FCNT_W-1:0] count;
   logic              full;
   logic              pop;
   logic              do_push;

   assign full    = (count == FIFO_FULL);
   assign pop     = cmd_valid & cmd_ready;
   assign do_push = push & (~full | pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         dir_mem[wr_ptr] <= push_dir;
         rep_mem[wr_ptr] <= push_rep;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push && full && !pop) overflow <= 1'b1;
      end
   end

   assign cmd_valid  = (count != '0);
   assign cmd_dir    = cmd_valid ? dir_mem[rd_ptr] : 3'd0;
   assign cmd_repeat = cmd_valid ? rep_mem[rd_ptr] : 1'b0;
   assign fifo_count = count;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler with short repeat timing (10/4) and a
// four-entry FIFO; expected command timing is hand-derived per step.
module tb_key_cmd_scheduler;

   logic       clk;
   logic       rst;
   logic [2:0] key_num;
   logic       key;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd_dir;
   logic       cmd_repeat;
   logic [2:0] fifo_count;
   logic       overflow;

   int n_checks = 0;
   int n_errors = 0;

   key_cmd_scheduler #(
      .REPEAT_DELAY  (10),
      .REPEAT_PERIOD (4),
      .FIFO_DEPTH    (4)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .key_num    (key_num),
      .key        (key),
      .cmd_ready  (cmd_ready),
      .cmd_valid  (cmd_valid),
      .cmd_dir    (cmd_dir),
      .cmd_repeat (cmd_repeat),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_head(input string tag, input logic v, input logic [2:0] d, input logic r);
      check({tag, " valid"},  8'(cmd_valid),  8'(v));
      check({tag, " dir"},    8'(cmd_dir),    8'(d));
      check({tag, " repeat"}, 8'(cmd_repeat), 8'(r));
   endtask

   logic [2:0] press_seq [5];
   logic [2:0] drain_seq [4];
   logic       ev;
   logic [2:0] ed;
   logic       er;

   initial begin
      // 1: key held through reset fires one press right after reset release
      rst = 1'b0; key = 1'b1; key_num = 3'd0; cmd_ready = 1'b1;
      step(); step(); step();
      check_head("t1 reset", 1'b0, 3'd0, 1'b0);
      check("t1 reset count", 8'(fifo_count), 8'd0);
      check("t1 reset overflow", 8'(overflow), 8'd0);
      rst = 1'b1;
      step();
      check_head("t1 first", 1'b1, 3'd0, 1'b0);
      check("t1 first count", 8'(fifo_count), 8'd1);
      key = 1'b0;
      step();
      check_head("t1 drained", 1'b0, 3'd0, 1'b0);
      step();
      check_head("t1 idle", 1'b0, 3'd0, 1'b0);

      // 2: held direction repeats at +1, +11, then every 4
      key_num = 3'd5; step(); step();
      key = 1'b1; key_num = 3'd3;
      for (int k = 1; k <= 30; k++) begin
         step();
         ev = (k == 1) || (k == 11) || (k == 15) || (k == 19) || (k == 23) || (k == 27);
         check_head($sformatf("t2 k%0d", k), ev, ev ? 3'd3 : 3'd0, ev && (k != 1));
      end
      key = 1'b0;
      for (int k = 31; k <= 35; k++) begin
         step();
         check_head($sformatf("t2 rel k%0d", k), 1'b0, 3'd0, 1'b0);
      end

      // 3: enter never repeats
      key_num = 3'd5; step();
      key = 1'b1; key_num = 3'd4;
      for (int k = 1; k <= 40; k++) begin
         step();
         ev = (k == 1);
         check_head($sformatf("t3 k%0d", k), ev, ev ? 3'd4 : 3'd0, 1'b0);
      end
      key = 1'b0; key_num = 3'd5;
      step(); step();
      check("t3 count", 8'(fifo_count), 8'd0);

      // 4: fill with consumer stalled, fifth press is dropped
      press_seq = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
      cmd_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         key = 1'b1; key_num = press_seq[i];
         step();
         key = 1'b0;
         step();
         if (i == 3) begin
            check("t4 full count", 8'(fifo_count), 8'd4);
            check("t4 full no overflow", 8'(overflow), 8'd0);
         end
      end
      check("t4 count", 8'(fifo_count), 8'd4);
      check("t4 overflow", 8'(overflow), 8'd1);
      cmd_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_head($sformatf("t4 drain %0d", i), 1'b1, 3'(i), 1'b0);
         step();
      end
      check_head("t4 empty", 1'b0, 3'd0, 1'b0);
      check("t4 empty count", 8'(fifo_count), 8'd0);
      check("t4 sticky overflow", 8'(overflow), 8'd1);

      // 5: push and pop together on a full FIFO neither drops nor overflows
      rst = 1'b0; key = 1'b0; key_num = 3'd5; cmd_ready = 1'b0;
      step(); step();
      rst = 1'b1;
      step();
      check("t5 overflow cleared", 8'(overflow), 8'd0);
      for (int i = 0; i < 4; i++) begin
         key = 1'b1; key_num = 3'(i);
         step();
         key = 1'b0;
         step();
      end
      check("t5 full", 8'(fifo_count), 8'd4);
      key = 1'b1; key_num = 3'd2; cmd_ready = 1'b1;
      step();
      check("t5 count stays", 8'(fifo_count), 8'd4);
      check("t5 no overflow", 8'(overflow), 8'd0);
      key = 1'b0;
      drain_seq = '{3'd1, 3'd2, 3'd3, 3'd2};
      for (int j = 0; j < 4; j++) begin
         check_head($sformatf("t5 drain %0d", j), 1'b1, drain_seq[j], 1'b0);
         step();
      end
      check_head("t5 empty", 1'b0, 3'd0, 1'b0);

      // 6: key switch restarts repeat timing; release on expiry cycle pushes nothing
      key_num = 3'd5; step();
      key = 1'b1; key_num = 3'd1;
      for (int k = 1; k <= 28; k++) begin
         step();
         ev = 1'b0; ed = 3'd0; er = 1'b0;
         if (k == 1) begin
            ev = 1'b1; ed = 3'd1;
         end else if (k == 7) begin
            ev = 1'b1; ed = 3'd2;
         end else if ((k == 17) || (k == 21)) begin
            ev = 1'b1; ed = 3'd2; er = 1'b1;
         end
         check_head($sformatf("t6 k%0d", k), ev, ed, er);
         if (k == 6)  key_num = 3'd2;
         if (k == 24) key = 1'b0;
      end
      check("t6 count", 8'(fifo_count), 8'd0);
      check("t6 overflow", 8'(overflow), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
